// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
// Groups the signals that fetch_ctrl exchanges with the backend, the IF->ID
// pipeline register and the instruction RAM port.
//   flush / flush_pc           redirect pulse and its target (backend -> fetch)
//   out_valid/out_ready        instruction handshake towards IF->ID
//   out_pc / out_instr         presented PC and instruction word
//   iram_req / iram_addr       read request and word-aligned address
//   iram_addr_ok               address accepted (req & addr_ok = accept)
//   iram_data_ok / iram_rdata  in-order read data return
// Modports: master = fetch_ctrl side, slave = environment side.
// Width comes from `XLEN (defaults to 32 when not defined elsewhere).

`ifndef XLEN
`define XLEN 32
`endif

interface fetch_ctrl_if;
  logic             flush;
  logic [`XLEN-1:0] flush_pc;
  logic             out_valid;
  logic             out_ready;
  logic [`XLEN-1:0] out_pc;
  logic [`XLEN-1:0] out_instr;
  logic             iram_req;
  logic [`XLEN-1:0] iram_addr;
  logic             iram_addr_ok;
  logic             iram_data_ok;
  logic [`XLEN-1:0] iram_rdata;

  modport master (
    input  flush, flush_pc, out_ready, iram_addr_ok, iram_data_ok, iram_rdata,
    output out_valid, out_pc, out_instr, iram_req, iram_addr
  );

  modport slave (
    output flush, flush_pc, out_ready, iram_addr_ok, iram_data_ok, iram_rdata,
    input  out_valid, out_pc, out_instr, iram_req, iram_addr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC, issues instruction RAM reads
// over a split address/data handshake, remembers the PC of every in-flight
// read, throws away responses that belong to the path abandoned by a redirect
// and presents {pc, instr} to the IF->ID register through valid/ready.
// Ports:
//   clk     clock
//   rst_b   asynchronous active-low reset
//   bus     fetch_ctrl_if.master (flush, output handshake, iram port)
// Parameter:
//   RESET_PC  first fetch address after reset (word aligned)
// Build option:
//   FETCH_SKID_EN  defined   -> capacity 2: two-deep in-flight PC FIFO and
//                               instruction buffer, back-to-back requests.
//                  undefined -> capacity 1: single registers, one read in flight.
// Every output except iram_req comes straight from a flop; iram_req also
// looks at flush and at the output pop so a full buffer can refill each cycle.

`ifndef XLEN
`define XLEN 32
`endif

module fetch_ctrl #(
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_b,
  fetch_ctrl_if.master bus
);
  localparam int XLEN = `XLEN;
`ifdef FETCH_SKID_EN
  localparam int          CW   = 2;
  localparam logic [CW:0] DCAP = 3'd2;
`else
  localparam int          CW   = 1;
  localparam logic [CW:0] DCAP = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   out_cnt, buf_cnt, disc_cnt;
  logic [CW-1:0]   out_cnt_nxt, buf_cnt_nxt, disc_cnt_nxt;
  logic [CW:0]     occ;
  logic            out_valid_q;
  logic [XLEN-1:0] head_pc, head_instr;
  logic [XLEN-1:0] fl_pc0;
`ifdef FETCH_SKID_EN
  logic [XLEN-1:0] fl_pc1, skid_pc, skid_instr;
  logic            fl_to_head, buf_to_head;
`endif
  logic            req, accept, resp, drop, push_buf, pop;

  // Occupancy counts discard-marked reads too, so a redirect cannot let the
  // stale responses overrun the buffer. A data_ok with nothing outstanding is
  // ignored entirely (resp stays low) so no counter can underflow.
  always_comb begin
    occ      = {1'b0, out_cnt} + {1'b0, buf_cnt};
    pop      = out_valid_q & bus.out_ready & ~bus.flush;
    resp     = bus.iram_data_ok & (out_cnt != '0);
    req      = (state != IDLE) & ~bus.flush &
               ((occ < DCAP) | ((occ == DCAP) & pop));
    accept   = req & bus.iram_addr_ok;
    drop     = resp & (bus.flush | (disc_cnt != '0));
    push_buf = resp & ~drop;

    out_cnt_nxt = out_cnt + CW'(accept) - CW'(resp);
    if (bus.flush) begin
      buf_cnt_nxt  = '0;
      disc_cnt_nxt = out_cnt_nxt;
    end else begin
      buf_cnt_nxt  = buf_cnt + CW'(push_buf) - CW'(pop);
      disc_cnt_nxt = disc_cnt - CW'(drop);
    end

    state_nxt = state;
    if (state == IDLE) begin
      state_nxt = FETCH;
    end else if (bus.flush || (state == DRAIN)) begin
      state_nxt = (disc_cnt_nxt != '0) ? DRAIN : FETCH;
    end
  end

`ifdef FETCH_SKID_EN
  // In both two-deep queues entry 0 is always the head; a new entry goes to
  // the head when the queue is empty or is emptied by the same cycle's pop.
  always_comb begin
    fl_to_head  = (out_cnt == 2'd0) || (resp && (out_cnt == 2'd1));
    buf_to_head = (buf_cnt == 2'd0) || (pop && (buf_cnt == 2'd1));
  end
`endif

  assign bus.iram_req  = req;
  assign bus.iram_addr = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_instr;

  // Whole controller state: FSM, PC, counters, in-flight PCs and the
  // instruction buffer whose head drives out_pc/out_instr directly.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_cnt     <= '0;
      buf_cnt     <= '0;
      disc_cnt    <= '0;
      out_valid_q <= 1'b0;
      head_pc     <= '0;
      head_instr  <= '0;
      fl_pc0      <= '0;
`ifdef FETCH_SKID_EN
      fl_pc1      <= '0;
      skid_pc     <= '0;
      skid_instr  <= '0;
`endif
    end else begin
      state       <= state_nxt;
      out_cnt     <= out_cnt_nxt;
      buf_cnt     <= buf_cnt_nxt;
      disc_cnt    <= disc_cnt_nxt;
      out_valid_q <= (buf_cnt_nxt != '0);

      if (bus.flush) begin
        pc <= {bus.flush_pc[XLEN-1:2], 2'b00};
      end else if (accept) begin
        pc <= pc + XLEN'(4);
      end

`ifdef FETCH_SKID_EN
      if (accept && fl_to_head) begin
        fl_pc0 <= pc;
      end else if (resp && (out_cnt == 2'd2)) begin
        fl_pc0 <= fl_pc1;
      end
      if (accept && !fl_to_head) begin
        fl_pc1 <= pc;
      end

      if (push_buf && buf_to_head) begin
        head_pc    <= fl_pc0;
        head_instr <= bus.iram_rdata;
      end else if (pop && (buf_cnt == 2'd2)) begin
        head_pc    <= skid_pc;
        head_instr <= skid_instr;
      end
      if (push_buf && !buf_to_head) begin
        skid_pc    <= fl_pc0;
        skid_instr <= bus.iram_rdata;
      end
`else
      if (accept) begin
        fl_pc0 <= pc;
      end
      if (push_buf) begin
        head_pc    <= fl_pc0;
        head_instr <= bus.iram_rdata;
      end
`endif
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Bench for fetch_ctrl: an in-order instruction RAM model with programmable
// latency (rdata = addr ^ FFFF_FFFF), a scoreboard of accepted fetch PCs that
// is cleared on redirect/reset and checked on every output handshake, and one
// task per scenario. A second instance starting at FFFF_FFFC exercises the
// PC wrap. Honors FETCH_SKID_EN to pick capacity 2 or 1.

module tb_fetch_ctrl;
`ifdef FETCH_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic        clk;
  logic        rst_b;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          hs_count = 0;
  int          mem_lat  = 1;
  logic [31:0] next_addr;
  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];

  fetch_ctrl_if bus();
  fetch_ctrl_if wbus();

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus.master)
  );

  fetch_ctrl #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (wbus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model and scoreboard, evaluated just after each falling edge once
  // the main sequence has driven this cycle's inputs.
  always @(negedge clk) begin : env
    mem_req_t    m;
    logic [31:0] e;
    #1;
    cyc++;
    if (!rst_b) begin
      mem_q.delete();
      exp_q.delete();
      next_addr        = RESET_PC;
      bus.iram_data_ok = 1'b0;
      bus.iram_rdata   = '0;
    end else begin
      if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
        m = mem_q.pop_front();
        bus.iram_data_ok = 1'b1;
        bus.iram_rdata   = m.addr ^ 32'hFFFF_FFFF;
      end else begin
        bus.iram_data_ok = 1'b0;
        bus.iram_rdata   = '0;
      end

      if (bus.flush) begin
        exp_q.delete();
        next_addr = {bus.flush_pc[31:2], 2'b00};
      end else if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_unexpected got pc=%h instr=%h with nothing expected",
                   bus.out_pc, bus.out_instr);
        end else begin
          e = exp_q.pop_front();
          if ((bus.out_pc !== e) || (bus.out_instr !== (e ^ 32'hFFFF_FFFF))) begin
            failures++;
            $display("[TB] FAIL sb_out got pc=%h instr=%h want pc=%h instr=%h",
                     bus.out_pc, bus.out_instr, e, e ^ 32'hFFFF_FFFF);
          end
        end
      end

      if (bus.iram_req && bus.iram_addr_ok) begin
        checks++;
        if (bus.iram_addr !== next_addr) begin
          failures++;
          $display("[TB] FAIL req_addr got=%h want=%h", bus.iram_addr, next_addr);
        end
        m.addr = bus.iram_addr;
        m.due  = cyc + mem_lat;
        mem_q.push_back(m);
        exp_q.push_back(bus.iram_addr);
        next_addr = next_addr + 32'd4;
      end
    end
  end

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.iram_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid_req got valid=%b req=%b want 0 0", bus.out_valid, bus.iram_req);
    end
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_out got pc=%h instr=%h want 0 0", bus.out_pc, bus.out_instr);
    end
    checks++;
    if (bus.iram_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL reset_addr got=%h want=%h", bus.iram_addr, RESET_PC);
    end
    checks++;
    if (wbus.iram_addr !== WRAP_PC) begin
      failures++;
      $display("[TB] FAIL reset_wrap_addr got=%h want=%h", wbus.iram_addr, WRAP_PC);
    end

    @(negedge clk);
    rst_b = 1'b1;
    #2;
    checks++;
    if (bus.iram_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_no_req got=%b want=0", bus.iram_req);
    end

    @(negedge clk);
    #2;
    checks++;
    if (bus.iram_req !== 1'b1 || bus.iram_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL first_fetch got req=%b addr=%h want 1 %h", bus.iram_req, bus.iram_addr, RESET_PC);
    end
    checks++;
    if (wbus.iram_req !== 1'b1 || wbus.iram_addr !== WRAP_PC) begin
      failures++;
      $display("[TB] FAIL wrap_first got req=%b addr=%h want 1 %h", wbus.iram_req, wbus.iram_addr, WRAP_PC);
    end

    @(negedge clk);
    #2;
    checks++;
    if (wbus.iram_addr !== 32'h0000_0000) begin
      failures++;
      $display("[TB] FAIL wrap_second got addr=%h want=00000000", wbus.iram_addr);
    end
  endtask

  task automatic test_stream();
    int h0;
    repeat (10) @(negedge clk);
    h0 = hs_count;
    repeat (20) @(negedge clk);
    checks++;
    if ((hs_count - h0) != 20 * D / 2) begin
      failures++;
      $display("[TB] FAIL stream_rate got=%0d want=%0d per 20 cycles", hs_count - h0, 20 * D / 2);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (bus.iram_req !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_saturate got req=%b valid=%b want 0 1", bus.iram_req, bus.out_valid);
    end
    checks++;
    if (exp_q.size() != D) begin
      failures++;
      $display("[TB] FAIL bp_occupancy got=%0d want=%0d", exp_q.size(), D);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_flush_inflight();
    bit found;
    @(negedge clk);
    bus.iram_addr_ok = 1'b0;
    repeat (6) @(negedge clk);
    mem_lat = 3;
    bus.flush        = 1'b1;
    bus.flush_pc     = 32'h0000_0010;
    bus.iram_addr_ok = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #2;
    checks++;
    if (bus.iram_req !== 1'b1 || bus.iram_addr !== 32'h10) begin
      failures++;
      $display("[TB] FAIL fi_req10 got req=%b addr=%h want 1 00000010", bus.iram_req, bus.iram_addr);
    end
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h0000_0203;
    @(negedge clk);
    bus.flush = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.iram_addr !== 32'h200) begin
      failures++;
      $display("[TB] FAIL fi_redirect got valid=%b addr=%h want 0 00000200", bus.out_valid, bus.iram_addr);
    end
    checks++;
    if (bus.iram_req !== (D == 2)) begin
      failures++;
      $display("[TB] FAIL fi_req_cap got=%b want=%b", bus.iram_req, (D == 2));
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.out_pc !== 32'h200 || bus.out_instr !== ~32'h200) begin
      failures++;
      $display("[TB] FAIL fi_first_out got seen=%b pc=%h instr=%h want 1 00000200 %h",
               found, bus.out_pc, bus.out_instr, ~32'h200);
    end
    mem_lat = 1;
  endtask

  task automatic test_flush_collide();
    bit found;
    repeat (6) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found        = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0344;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL fc_no_valid got out_valid=0 for 20 cycles want 1");
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.iram_req !== 1'b1 || bus.iram_addr !== 32'h344) begin
      failures++;
      $display("[TB] FAIL fc_redirect got valid=%b req=%b addr=%h want 0 1 00000344",
               bus.out_valid, bus.iram_req, bus.iram_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.out_pc !== 32'h344) begin
      failures++;
      $display("[TB] FAIL fc_first_out got seen=%b pc=%h want 1 00000344", found, bus.out_pc);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    repeat (5) @(negedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.iram_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_immediate got valid=%b req=%b want 0 0", bus.out_valid, bus.iram_req);
    end
    checks++;
    if (bus.iram_addr !== RESET_PC || bus.out_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL ar_values got addr=%h pc=%h want %h 0", bus.iram_addr, bus.out_pc, RESET_PC);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (bus.iram_req !== 1'b1 || bus.iram_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL ar_restart got req=%b addr=%h want 1 %h", bus.iram_req, bus.iram_addr, RESET_PC);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.out_pc !== RESET_PC || bus.out_instr !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL ar_first_out got seen=%b pc=%h instr=%h want 1 %h FFFFFFFF",
               found, bus.out_pc, bus.out_instr, RESET_PC);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_b             = 1'b0;
    bus.flush         = 1'b0;
    bus.flush_pc      = '0;
    bus.out_ready     = 1'b1;
    bus.iram_addr_ok  = 1'b1;
    bus.iram_data_ok  = 1'b0;
    bus.iram_rdata    = '0;
    wbus.flush        = 1'b0;
    wbus.flush_pc     = '0;
    wbus.out_ready    = 1'b0;
    wbus.iram_addr_ok = 1'b1;
    wbus.iram_data_ok = 1'b0;
    wbus.iram_rdata   = '0;
    $display("[TB] start, capacity %0d", D);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_flush_collide();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish within time limit want finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
